// File: rtl/ks_recomp_pkg.sv
// Default TFHE keyswitch parameters, followed by the constants and helpers
// shared by the digit recomposer and its per-lane datapath.
package param_tfhe_definition_pkg;
  localparam int KS_L      = 8;
  localparam int KS_B_W    = 2;
  localparam int MOD_KSK_W = 21;
endpackage

package ks_recomp_pkg;
  import param_tfhe_definition_pkg::*;

  localparam int DIGIT_W   = KS_B_W + 1;
  localparam int DIGIT_MAX = 2 ** (KS_B_W - 1);
  localparam int DIGIT_MIN = -DIGIT_MAX;

  // Largest magnitude a balanced digit of b_w bits may legally take.
  function automatic int digit_max(input int b_w);
    return 2 ** (b_w - 1);
  endfunction

  // Left shift that places a level-lvl digit inside the mod_w-bit coefficient.
  function automatic int lvl_shift(input int mod_w, input int lvl, input int b_w);
    return mod_w - lvl * b_w;
  endfunction
endpackage

// File: rtl/ks_recomp_lane.sv
// One lane of the recomposer: the running accumulator, the shifted digit add
// (modulo 2^MOD_KSK_W) and the balanced-digit range check.
module ks_recomp_lane
  import ks_recomp_pkg::*;
#(
  parameter int KS_B_W    = param_tfhe_definition_pkg::KS_B_W,
  parameter int MOD_KSK_W = param_tfhe_definition_pkg::MOD_KSK_W,
  parameter int SH_W      = $clog2(MOD_KSK_W + 1)
) (
  input  logic                  clk,
  input  logic                  a_rst_n,
  input  logic signed [KS_B_W:0] digit,
  input  logic [SH_W-1:0]       shift,
  input  logic                  acc_en,
  input  logic                  grp_done,
  output logic [MOD_KSK_W-1:0]  sum,
  output logic                  range_err
);
  localparam logic signed [KS_B_W:0] DMAX = (KS_B_W + 1)'(digit_max(KS_B_W));
  localparam logic signed [KS_B_W:0] DMIN = -DMAX;

  logic [MOD_KSK_W-1:0] digit_sx;
  logic [MOD_KSK_W-1:0] acc_p0;

  assign digit_sx  = {{(MOD_KSK_W - KS_B_W - 1){digit[KS_B_W]}}, digit};
  assign sum       = acc_p0 + (digit_sx << shift);
  assign range_err = (digit > DMAX) || (digit < DMIN);

  // p0: running partial sum of the current group
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      acc_p0 <= '0;
    end else if (acc_en) begin
      acc_p0 <= grp_done ? '0 : sum;
    end
  end
endmodule

// File: rtl/ks_digit_recomposer.sv
// Rebuilds MOD_KSK_W-bit coefficients from balanced signed keyswitch digits,
// LANE_NB lanes in parallel, one level per accepted beat (LSB level first).
module ks_digit_recomposer
  import ks_recomp_pkg::*;
#(
  parameter int KS_L      = param_tfhe_definition_pkg::KS_L,
  parameter int KS_B_W    = param_tfhe_definition_pkg::KS_B_W,
  parameter int MOD_KSK_W = param_tfhe_definition_pkg::MOD_KSK_W,
  parameter int LANE_NB   = 4
) (
  input  logic                           clk,
  input  logic                           a_rst_n,
  input  logic [LANE_NB*(KS_B_W+1)-1:0]  in_data,
  input  logic                           in_last,
  input  logic                           in_vld,
  output logic                           in_rdy,
  output logic [LANE_NB*MOD_KSK_W-1:0]   out_data,
  output logic                           out_vld,
  input  logic                           out_rdy,
  output logic                           err_range,
  output logic                           err_last
);
  localparam int DW    = KS_B_W + 1;
  localparam int LVL_W = $clog2(KS_L + 1);
  localparam int SH_W  = $clog2(MOD_KSK_W + 1);
  localparam logic [LVL_W-1:0] LVL_INIT = LVL_W'(KS_L);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

  logic [LVL_W-1:0]             lvl_p0;
  logic [SH_W-1:0]              shift;
  logic                         accept;
  logic                         lvl_is_one;
  logic                         grp_done;
  logic [LANE_NB-1:0]           lane_err;
  logic [LANE_NB*MOD_KSK_W-1:0] lane_sum;

  assign in_rdy     = ~out_vld | out_rdy;
  assign accept     = in_vld & in_rdy;
  assign lvl_is_one = (lvl_p0 == LVL_ONE);
  // A group closes on in_last or on the final level, so a misplaced in_last resyncs.
  assign grp_done   = accept & (in_last | lvl_is_one);
  assign shift      = SH_W'(lvl_shift(MOD_KSK_W, int'(lvl_p0), KS_B_W));

  for (genvar i = 0; i < LANE_NB; i++) begin : g_lane
    ks_recomp_lane #(
      .KS_B_W   (KS_B_W),
      .MOD_KSK_W(MOD_KSK_W),
      .SH_W     (SH_W)
    ) u_lane (
      .clk      (clk),
      .a_rst_n  (a_rst_n),
      .digit    (in_data[i*DW +: DW]),
      .shift    (shift),
      .acc_en   (accept),
      .grp_done (grp_done),
      .sum      (lane_sum[i*MOD_KSK_W +: MOD_KSK_W]),
      .range_err(lane_err[i])
    );
  end

  // p0: level counter and error flags
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      lvl_p0    <= LVL_INIT;
      err_range <= 1'b0;
      err_last  <= 1'b0;
    end else begin
      err_range <= accept & (|lane_err);
      err_last  <= accept & (in_last ^ lvl_is_one);
      if (accept) begin
        lvl_p0 <= grp_done ? LVL_INIT : lvl_p0 - LVL_ONE;
      end
    end
  end

  // p1: single-entry output register
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      out_data <= '0;
      out_vld  <= 1'b0;
    end else if (grp_done) begin
      out_data <= lane_sum;
      out_vld  <= 1'b1;
    end else if (out_vld && out_rdy) begin
      out_vld  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ks_digit_recomposer.sv
// Bench for ks_digit_recomposer: directed groups with literal expectations plus
// randomized traffic checked every cycle against an arithmetic reference model.
module tb_ks_digit_recomposer;
  localparam int KS_L      = 8;
  localparam int KS_B_W    = 2;
  localparam int MOD_KSK_W = 21;
  localparam int LANE_NB   = 4;
  localparam int DW        = KS_B_W + 1;
  localparam longint MODV  = longint'(1) << MOD_KSK_W;

  logic                         clk = 1'b0;
  logic                         a_rst_n = 1'b0;
  logic [LANE_NB*DW-1:0]        in_data = '0;
  logic                         in_last = 1'b0;
  logic                         in_vld = 1'b0;
  logic                         in_rdy;
  logic [LANE_NB*MOD_KSK_W-1:0] out_data;
  logic                         out_vld;
  logic                         out_rdy = 1'b0;
  logic                         err_range;
  logic                         err_last;

  int n_tests = 0;
  int n_fail  = 0;

  bit     m_out_vld, m_err_range, m_err_last;
  longint m_acc[LANE_NB];
  longint m_out[LANE_NB];
  int     m_lvl;

  ks_digit_recomposer #(
    .KS_L(KS_L), .KS_B_W(KS_B_W), .MOD_KSK_W(MOD_KSK_W), .LANE_NB(LANE_NB)
  ) dut (
    .clk(clk), .a_rst_n(a_rst_n), .in_data(in_data), .in_last(in_last),
    .in_vld(in_vld), .in_rdy(in_rdy), .out_data(out_data), .out_vld(out_vld),
    .out_rdy(out_rdy), .err_range(err_range), .err_last(err_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_out_vld   = 0;
    m_err_range = 0;
    m_err_last  = 0;
    m_lvl       = KS_L;
    for (int l = 0; l < LANE_NB; l++) begin
      m_acc[l] = 0;
      m_out[l] = 0;
    end
  endtask

  task automatic model_step(input bit vld, input bit last, input int d[LANE_NB], input bit ordy);
    bit rdy, acc, done, rng;
    rdy = !m_out_vld || ordy;
    acc = vld && rdy;
    rng = 0;
    for (int l = 0; l < LANE_NB; l++)
      if (d[l] > 2 || d[l] < -2) rng = 1;
    m_err_range = acc && rng;
    m_err_last  = acc && (last != (m_lvl == 1));
    if (acc)
      for (int l = 0; l < LANE_NB; l++)
        m_acc[l] = ((m_acc[l] + longint'(d[l]) * (longint'(1) << (MOD_KSK_W - m_lvl * KS_B_W)))
                    % MODV + MODV) % MODV;
    done = acc && (last || m_lvl == 1);
    if (done) begin
      for (int l = 0; l < LANE_NB; l++) begin
        m_out[l] = m_acc[l];
        m_acc[l] = 0;
      end
      m_out_vld = 1;
      m_lvl     = KS_L;
    end else begin
      if (acc) m_lvl--;
      if (m_out_vld && ordy) m_out_vld = 0;
    end
  endtask

  task automatic check_all();
    chk("in_rdy", 64'(in_rdy), longint'(!m_out_vld || out_rdy));
    chk("out_vld", 64'(out_vld), longint'(m_out_vld));
    chk("err_range", 64'(err_range), longint'(m_err_range));
    chk("err_last", 64'(err_last), longint'(m_err_last));
    for (int l = 0; l < LANE_NB; l++)
      chk($sformatf("out_data[%0d]", l), 64'(out_data[l*MOD_KSK_W +: MOD_KSK_W]), m_out[l]);
  endtask

  task automatic step(input bit vld, input bit last, input int d[LANE_NB], input bit ordy);
    for (int l = 0; l < LANE_NB; l++) in_data[l*DW +: DW] = DW'(d[l]);
    in_vld  = vld;
    in_last = last;
    out_rdy = ordy;
    @(posedge clk);
    model_step(vld, last, d, ordy);
    #1;
    check_all();
  endtask

  // Sends one full group; lv_digit[k] is the digit for level k+1, same on every lane.
  task automatic send_group(input int lv_digit[KS_L]);
    int dd[LANE_NB];
    for (int k = KS_L; k >= 1; k--) begin
      for (int l = 0; l < LANE_NB; l++) dd[l] = lv_digit[k-1];
      step(1, k == 1, dd, 1);
    end
  endtask

  task automatic do_reset();
    in_vld  = 0;
    a_rst_n = 0;
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    a_rst_n = 1;
  endtask

  initial begin
    int z[LANE_NB];
    int dd[LANE_NB];
    for (int l = 0; l < LANE_NB; l++) z[l] = 0;
    model_reset();
    #12;
    check_all();
    a_rst_n = 1;

    send_group('{0, 0, 0, 0, 0, 0, 0, 0});
    chk("lit_zero", 64'(out_data[MOD_KSK_W-1:0]), 64'h000000);
    send_group('{1, 0, 0, 0, 0, 0, 0, 0});
    chk("lit_l1_plus1", 64'(out_data[MOD_KSK_W-1:0]), 64'h080000);
    send_group('{-1, 0, 0, 0, 0, 0, 0, 0});
    chk("lit_l1_minus1", 64'(out_data[MOD_KSK_W-1:0]), 64'h180000);
    send_group('{2, 2, 2, 2, 2, 2, 2, 2});
    chk("lit_all_plus2", 64'(out_data[2*MOD_KSK_W-1:MOD_KSK_W]), 64'h155540);
    send_group('{2, 0, 0, 0, 0, 0, 0, 0});
    chk("lit_l1_plus2", 64'(out_data[MOD_KSK_W-1:0]), 64'h100000);
    send_group('{-2, 0, 0, 0, 0, 0, 0, 0});
    chk("lit_l1_minus2", 64'(out_data[MOD_KSK_W-1:0]), 64'h100000);

    // +3 at level 4 is out of range but still accumulated
    for (int k = KS_L; k >= 1; k--) begin
      for (int l = 0; l < LANE_NB; l++) dd[l] = (k == 4) ? 3 : 0;
      step(1, k == 1, dd, 1);
      if (k == 4) chk("lit_err_range", 64'(err_range), 1);
    end
    chk("lit_range_val", 64'(out_data[MOD_KSK_W-1:0]), 64'h006000);

    // Early in_last on beat 5 closes a partial group
    for (int l = 0; l < LANE_NB; l++) dd[l] = 1;
    for (int b = 1; b <= 5; b++) step(1, b == 5, dd, 1);
    chk("lit_err_last", 64'(err_last), 1);
    chk("lit_partial", 64'(out_data[MOD_KSK_W-1:0]), 64'h002AA0);
    send_group('{2, 2, 2, 2, 2, 2, 2, 2});
    chk("lit_resync", 64'(out_data[MOD_KSK_W-1:0]), 64'h155540);

    // Output stalled for 20 cycles while input keeps offering beats
    send_group('{1, 1, 1, 1, 1, 1, 1, 1});
    for (int c = 0; c < 20; c++) begin
      for (int l = 0; l < LANE_NB; l++) dd[l] = int'($urandom_range(0, 4)) - 2;
      step(1, m_lvl == 1, dd, 0);
      chk("lit_stall_rdy", 64'(in_rdy), 0);
    end
    for (int c = 0; c < 24; c++) begin
      for (int l = 0; l < LANE_NB; l++) dd[l] = int'($urandom_range(0, 4)) - 2;
      step(1, m_lvl == 1, dd, 1);
    end

    // Reset in the middle of a group discards the partial sum
    send_group('{0, 0, 0, 0, 0, 0, 0, 0});
    for (int l = 0; l < LANE_NB; l++) dd[l] = 1;
    for (int b = 0; b < 3; b++) step(1, 0, dd, 1);
    do_reset();
    chk("lit_rst_vld", 64'(out_vld), 0);
    send_group('{2, 2, 2, 2, 2, 2, 2, 2});
    chk("lit_after_rst", 64'(out_data[MOD_KSK_W-1:0]), 64'h155540);

    // Randomized traffic with occasional range and framing errors
    for (int c = 0; c < 800; c++) begin
      bit vld, last, ordy;
      for (int l = 0; l < LANE_NB; l++)
        dd[l] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) - 4
                                            : int'($urandom_range(0, 4)) - 2;
      vld  = ($urandom_range(0, 9) < 8);
      ordy = ($urandom_range(0, 9) < 7);
      last = (m_lvl == 1) ^ ($urandom_range(0, 19) == 0);
      step(vld, last, dd, ordy);
    end
    step(0, 0, z, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
